trace_dump_ctrl: RTL
====================

# trace_dump_ctrl

Sequencer and RAM arbiter that unloads a completed capture from the 512-entry sample RAM to the host UART transmitter. It sits between the capture engine (en/we/addr) and the sample RAM. It grants the RAM to the capture engine while idle. On a host dump command it takes ownership, reads the circular trace oldest-first starting at trace_end+1, and hands each byte to the UART transmit handshake. When the dump is complete it releases the capture-done status so the next capture can arm.

## Interface
- ADDR_W, 9, RAM address width; trace length is 2^ADDR_W samples
- DATA_W, 8, sample width and UART byte width
- clk  in  1  system clock, all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- dump_req  in  1  one-cycle host command pulse requesting a trace dump
- cap_done  in  1  capture-complete status bit from the trigger config register
- trace_end  in  ADDR_W  address of the newest captured sample
- cap_en, cap_we  in  1  capture engine RAM enable / write enable
- cap_addr  in  ADDR_W  capture engine RAM address
- ram_rdata  in  DATA_W  RAM read data, valid one clk after ram_en
- ram_en, ram_we  out  1  RAM enable / write enable
- ram_addr  out  ADDR_W  RAM address
- tx_data  out  DATA_W  byte to UART transmitter
- trmt  out  1  one-cycle transmit strobe to UART
- tx_done  in  1  UART byte-complete pulse
- dump_busy  out  1  high while a dump owns the RAM
- dump_done  out  1  one-cycle pulse on dump completion
- dump_err  out  1  one-cycle pulse when dump_req is rejected
- clr_cap_done  out  1  one-cycle pulse clearing cap_done

## Operation
- States: IDLE, RD, LATCH, TX, WAIT_TX, DONE.
- IDLE:
  - RAM muxed combinationally to capture engine: ram_en=cap_en, ram_we=cap_we, ram_addr=cap_addr.
  - dump_req with cap_done=1: load rd_ptr=trace_end+1 (ADDR_W-bit wrap, 511+1→0), clear byte_cnt, go to RD.
  - dump_req with cap_done=0: pulse dump_err next cycle, stay IDLE.
- Any state other than IDLE:
  - ram_we=0, ram_addr=rd_ptr, dump_busy=1.
  - cap_en/cap_we are ignored, never forwarded to the RAM.
- RD: ram_en=1 for one cycle, then go to LATCH.
- LATCH: register ram_rdata into tx_data, then go to TX.
- TX: trmt=1 for one cycle; rd_ptr+=1 (wraps); go to WAIT_TX.
- WAIT_TX, on tx_done:
  - byte_cnt==2^ADDR_W−1 → DONE.
  - otherwise byte_cnt+=1 and go to RD.
  - tx_done in any other state is ignored.
- DONE: dump_done=1 and clr_cap_done=1 for one cycle, then go to IDLE.
- byte_cnt is ADDR_W+1 bits wide. Exactly 2^ADDR_W bytes are sent per dump.
- dump_req while dump_busy is ignored: no error, no restart.
- tx_data holds its last value between loads.

## Timing
- Reset values: state=IDLE, tx_data=0, rd_ptr=0, byte_cnt=0, trmt=0, dump_busy=0, dump_done=0, dump_err=0, clr_cap_done=0.
- In reset, ram_en/ram_we/ram_addr follow the capture inputs (IDLE mux).
- dump_req accepted at edge N:
  - dump_busy=1 and ram_en=1 in cycle N+1.
  - tx_data valid at N+3 with trmt=1 at N+3.
- Per byte: 3 cycles + UART time. tx_done at edge M → next ram_en in cycle M+1.
- Final tx_done at edge M:
  - dump_done and clr_cap_done high in cycle M+1.
  - dump_busy low and IDLE mux restored in cycle M+2.
- dump_err is registered: high in cycle N+1 for a rejected request at edge N.
- Reset asserted mid-dump:
  - Immediate return to IDLE; all outputs take reset values.
  - No dump_done and no clr_cap_done.
  - RAM is returned to the capture engine at once.
- Capture strobes arriving during a dump are dropped, not queued.

## Test plan
- Reset, then cap_en=1, cap_we=1, cap_addr=0x05 in IDLE → ram_en=1, ram_we=1, ram_addr=0x05 in the same cycle.
- Preload RAM[i]=i[7:0], trace_end=0x1FF, cap_done=1, pulse dump_req, tx_done 10 cycles after each trmt:
  - 512 trmt pulses, bytes 0x00,0x01..0xFF,0x00..0xFF.
  - Single dump_done and clr_cap_done after the 512th tx_done.
- trace_end=0x0FA, same RAM → first tx_data=0xFB; byte 6 is 0x00 from addr 0x100; last byte 0xFA.
- dump_req with cap_done=0 → dump_err pulse one cycle later; dump_busy stays 0; no ram_en.
- During a dump: second dump_req plus cap_we=1 pulses → no restart, ram_we stays 0, byte sequence unchanged.
- rst_n low after byte 100 → dump_busy=0 and trmt=0 immediately; no dump_done; a new dump_req afterwards restarts from trace_end+1.

Source files
------------

// File: rtl/trace_dump_ctrl.sv
// -----------------------------------------------------------------------------
// trace_dump_ctrl
//
// Unloads a finished capture from the circular sample RAM to the host UART.
// While idle, the capture engine owns the RAM through a combinational mux.
// A dump command is accepted only when a capture is complete. Once accepted,
// the controller owns the RAM and reads the trace oldest-first, starting at
// trace_end+1 and wrapping around the address space. Each byte is handed to
// the UART with a one-cycle trmt strobe, and the controller waits for tx_done
// before it fetches the next byte. After the last byte it pulses dump_done and
// clr_cap_done so that the next capture can arm.
//
// Ports
//   clk, rst_n         system clock, asynchronous active-low reset
//   i_dump_req         one-cycle host dump command
//   i_cap_done         capture-complete status
//   i_trace_end        address of the newest captured sample
//   i_cap_en/we/addr   capture engine RAM access (forwarded only while idle)
//   i_ram_rdata        RAM read data, valid one cycle after o_ram_en
//   i_tx_done          UART byte-complete pulse
//   o_ram_en/we/addr   RAM access port
//   o_tx_data, o_trmt  UART byte and one-cycle transmit strobe
//   o_dump_busy        high while a dump owns the RAM
//   o_dump_done        one-cycle pulse when a dump completes
//   o_dump_err         one-cycle pulse when a dump request is rejected
//   o_clr_cap_done     one-cycle pulse that clears the capture-done status
// -----------------------------------------------------------------------------
module trace_dump_ctrl #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_dump_req,
  input  logic              i_cap_done,
  input  logic [ADDR_W-1:0] i_trace_end,
  input  logic              i_cap_en,
  input  logic              i_cap_we,
  input  logic [ADDR_W-1:0] i_cap_addr,
  input  logic [DATA_W-1:0] i_ram_rdata,
  input  logic              i_tx_done,
  output logic              o_ram_en,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_tx_data,
  output logic              o_trmt,
  output logic              o_dump_busy,
  output logic              o_dump_done,
  output logic              o_dump_err,
  output logic              o_clr_cap_done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD      = 3'd1,
    S_LATCH   = 3'd2,
    S_TX      = 3'd3,
    S_WAIT_TX = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  // The byte counter indexes the bytes of the dump, so the final byte has
  // index 2^ADDR_W - 1. The counter is one bit wider than the address.
  localparam logic [ADDR_W:0]   C_LAST_BYTE = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0]   C_CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] C_PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_byte_cnt;
  logic [DATA_W-1:0] r_tx_data;
  logic              r_trmt;
  logic              r_dump_busy;
  logic              r_dump_done;
  logic              r_dump_err;
  logic              r_clr_cap_done;

  logic              w_idle;

  assign w_idle = (r_state == S_IDLE);

  // Dump sequencer: the state, the read pointer, the byte count and all
  // registered status/handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_rd_ptr       <= {ADDR_W{1'b0}};
      r_byte_cnt     <= {(ADDR_W+1){1'b0}};
      r_tx_data      <= {DATA_W{1'b0}};
      r_trmt         <= 1'b0;
      r_dump_busy    <= 1'b0;
      r_dump_done    <= 1'b0;
      r_dump_err     <= 1'b0;
      r_clr_cap_done <= 1'b0;
    end else begin
      // Strobes default low, so each one lasts exactly one cycle.
      r_trmt         <= 1'b0;
      r_dump_done    <= 1'b0;
      r_dump_err     <= 1'b0;
      r_clr_cap_done <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (i_dump_req) begin
            if (i_cap_done) begin
              // Oldest sample sits just past the newest one; the sum wraps
              // naturally at ADDR_W bits.
              r_rd_ptr    <= i_trace_end + C_PTR_ONE;
              r_byte_cnt  <= {(ADDR_W+1){1'b0}};
              r_dump_busy <= 1'b1;
              r_state     <= S_RD;
            end else begin
              r_dump_err  <= 1'b1;
            end
          end
        end

        S_RD: begin
          r_state <= S_LATCH;
        end

        S_LATCH: begin
          // The RAM data from the RD cycle is valid now. Raise trmt together
          // with the new byte so both appear in the same TX cycle.
          r_tx_data <= i_ram_rdata;
          r_trmt    <= 1'b1;
          r_state   <= S_TX;
        end

        S_TX: begin
          r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
          r_state  <= S_WAIT_TX;
        end

        S_WAIT_TX: begin
          if (i_tx_done) begin
            if (r_byte_cnt == C_LAST_BYTE) begin
              r_dump_done    <= 1'b1;
              r_clr_cap_done <= 1'b1;
              r_state        <= S_DONE;
            end else begin
              r_byte_cnt <= r_byte_cnt + C_CNT_ONE;
              r_state    <= S_RD;
            end
          end
        end

        S_DONE: begin
          r_dump_busy <= 1'b0;
          r_state     <= S_IDLE;
        end

        default: begin
          r_dump_busy <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  // RAM ownership mux: the capture engine drives the RAM while idle (and
  // therefore also during reset). During a dump the controller drives it
  // read-only, and capture strobes are dropped.
  always_comb begin
    o_ram_en   = 1'b0;
    o_ram_we   = 1'b0;
    o_ram_addr = {ADDR_W{1'b0}};
    if (w_idle) begin
      o_ram_en   = i_cap_en;
      o_ram_we   = i_cap_we;
      o_ram_addr = i_cap_addr;
    end else begin
      o_ram_en   = (r_state == S_RD);
      o_ram_we   = 1'b0;
      o_ram_addr = r_rd_ptr;
    end
  end

  assign o_tx_data      = r_tx_data;
  assign o_trmt         = r_trmt;
  assign o_dump_busy    = r_dump_busy;
  assign o_dump_done    = r_dump_done;
  assign o_dump_err     = r_dump_err;
  assign o_clr_cap_done = r_clr_cap_done;

endmodule
